// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide sequencer for the MIPS EX stage.
// Holds a MULT/MULTU/DIV/DIVU result for a fixed latency before committing it to HI/LO.
module md_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_tHi;
    logic [31:0]      r_tLo;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_busy;
    logic             r_done;

    logic [63:0] w_prodS;
    logic [63:0] w_prodU;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [31:0] w_divisorS;
    logic [31:0] w_divisorU;
    logic [31:0] w_qMag;
    logic [31:0] w_rMag;
    logic [31:0] w_qS;
    logic [31:0] w_rS;
    logic [31:0] w_qU;
    logic [31:0] w_rU;
    logic [31:0] w_resHi;
    logic [31:0] w_resLo;

    assign w_prodS = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prodU = {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes, so 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_magA     = A[31] ? -A : A;
    assign w_magB     = B[31] ? -B : B;
    assign w_divisorS = (w_magB == 32'd0) ? 32'd1 : w_magB;
    assign w_qMag     = w_magA / w_divisorS;
    assign w_rMag     = w_magA % w_divisorS;
    assign w_qS       = (A[31] ^ B[31]) ? -w_qMag : w_qMag;
    assign w_rS       = A[31] ? -w_rMag : w_rMag;

    assign w_divisorU = (B == 32'd0) ? 32'd1 : B;
    assign w_qU       = A / w_divisorU;
    assign w_rU       = A % w_divisorU;

    always_comb begin
        w_resHi = 32'd0;
        w_resLo = 32'd0;
        case (md_op)
            3'd0: {w_resHi, w_resLo} = w_prodS;
            3'd1: {w_resHi, w_resLo} = w_prodU;
            3'd2: {w_resHi, w_resLo} = (B == 32'd0) ? {A, 32'hFFFF_FFFF} : {w_rS, w_qS};
            3'd3: {w_resHi, w_resLo} = (B == 32'd0) ? {A, 32'hFFFF_FFFF} : {w_rU, w_qU};
            default: ;
        endcase
    end

    // Flush is tested before the commit so a squashed op never reaches HI/LO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tHi   <= 32'd0;
            r_tLo   <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !flush) begin
                        case (md_op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                r_tHi   <= w_resHi;
                                r_tLo   <= w_resLo;
                                r_cnt   <= md_op[1] ? DIV_LOAD : MUL_LOAD;
                                r_state <= RUN;
                                r_busy  <= 1'b1;
                            end
                            3'd4:    r_hi <= A;
                            3'd5:    r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (flush) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_hi    <= r_tHi;
                        r_lo    <= r_tLo;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
